// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared types and defaults for the instruction fetch stage.
//   state_t      FSM encoding (S_IDLE=0, S_REQ=1, S_VALID=2)
//   PC_W_DEF     default ROM address width
//   INSTR_W_DEF  default instruction width
//   pc_next()    increment-with-wrap helper for the program counter
package instr_fetch_pkg;

    localparam int PC_W_DEF    = 3;
    localparam int INSTR_W_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } state_t;

    // Wraps naturally at 2**PC_W; the PC is at most 32 bits wide.
    function automatic logic [31:0] pc_next(input logic [31:0] pc, input int pc_w);
        logic [31:0] mask;
        mask    = (pc_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << pc_w) - 32'd1);
        pc_next = (pc + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: ROM bus and decode handshake of the fetch stage.
//   rom_pc / rom_oeb / rom_instr   ROM address, active-low enable, data
//   ir_instr / ir_pc / ir_valid    captured word towards decode
//   ir_ready                       decode accepts the word
// Modports: master = fetch stage, slave = ROM + decode side.
interface instr_fetch_if #(
    parameter int PC_W    = 3,
    parameter int INSTR_W = 16
);
    logic [PC_W-1:0]    rom_pc;
    logic               rom_oeb;
    logic [INSTR_W-1:0] rom_instr;
    logic [INSTR_W-1:0] ir_instr;
    logic [PC_W-1:0]    ir_pc;
    logic               ir_valid;
    logic               ir_ready;

    modport master (
        output rom_pc, rom_oeb, ir_instr, ir_pc, ir_valid,
        input  rom_instr, ir_ready
    );

    modport slave (
        input  rom_pc, rom_oeb, ir_instr, ir_pc, ir_valid,
        output rom_instr, ir_ready
    );
endinterface

// File: rtl/instr_fetch_pc_reg.sv
// fetch_pc_reg: program counter register.
//   clk, rst          clock, synchronous active-high reset (loads RESET_PC)
//   redirect_valid    load redirect_pc
//   redirect_pc       new fetch address
//   inc               advance by one, wrapping at 2**PC_W
//   pc                current program counter
// Priority: rst > redirect > increment.
module fetch_pc_reg #(
    parameter int PC_W     = 3,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);
    always_ff @(posedge clk) begin
        if (rst)
            pc <= PC_W'(RESET_PC);
        else if (redirect_valid)
            pc <= redirect_pc;
        else if (inc)
            pc <= pc + PC_W'(1);
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage in front of the instruction ROM.
//   clk, rst                      clock, synchronous active-high reset
//   en                            run enable; 0 stops issuing new fetches
//   redirect_valid, redirect_pc   branch/jump redirect (one-cycle pulse)
//   bus (instr_fetch_if.master)   ROM address/enable/data, IR valid/ready
//   fetch_count[15:0]             handshake counter, present only when
//                                 INSTR_FETCH_COUNT_EN is defined
// One read at a time: IDLE -> REQ (rom_oeb low for SETTLE_CYC cycles) ->
// VALID (word held until decode accepts) -> REQ or IDLE.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int INSTR_W    = INSTR_W_DEF,
    parameter int RESET_PC   = 0,
    parameter int SETTLE_CYC = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    instr_fetch_if.master   bus
`ifdef INSTR_FETCH_COUNT_EN
    ,
    output logic [15:0]     fetch_count
`endif
);
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t             state;
    logic [CNT_W-1:0]   settle_cnt;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    rom_pc_q;
    logic               rom_oeb_q;
    logic [INSTR_W-1:0] ir_instr_q;
    logic [PC_W-1:0]    ir_pc_q;
    logic               ir_valid_q;
    logic               settle_done;
    logic               pc_inc;

    assign settle_done = (settle_cnt == CNT_W'(SETTLE_CYC - 1));
    assign pc_inc      = (state == S_REQ) && settle_done && !redirect_valid;

    fetch_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inc            (pc_inc),
        .pc             (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            rom_pc_q   <= PC_W'(RESET_PC);
            rom_oeb_q  <= 1'b1;
            ir_instr_q <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else if (redirect_valid) begin
            // Abandon whatever is in flight or held; restart at the new PC.
            ir_valid_q <= 1'b0;
            settle_cnt <= '0;
            if (en) begin
                state     <= S_REQ;
                rom_oeb_q <= 1'b0;
                rom_pc_q  <= redirect_pc;
            end else begin
                state     <= S_IDLE;
                rom_oeb_q <= 1'b1;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) begin
                        state      <= S_REQ;
                        rom_oeb_q  <= 1'b0;
                        rom_pc_q   <= pc;
                        settle_cnt <= '0;
                    end
                end
                S_REQ: begin
                    // en is ignored here: a started read always completes.
                    if (settle_done) begin
                        ir_instr_q <= bus.rom_instr;
                        ir_pc_q    <= pc;
                        ir_valid_q <= 1'b1;
                        rom_oeb_q  <= 1'b1;
                        state      <= S_VALID;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                S_VALID: begin
                    if (bus.ir_ready) begin
                        ir_valid_q <= 1'b0;
                        settle_cnt <= '0;
                        if (en) begin
                            state     <= S_REQ;
                            rom_oeb_q <= 1'b0;
                            rom_pc_q  <= pc;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    rom_oeb_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rom_pc   = rom_pc_q;
    assign bus.rom_oeb  = rom_oeb_q;
    assign bus.ir_instr = ir_instr_q;
    assign bus.ir_pc    = ir_pc_q;
    assign bus.ir_valid = ir_valid_q;

`ifdef INSTR_FETCH_COUNT_EN
    // A ready that collides with a redirect is not a handshake.
    always_ff @(posedge clk) begin
        if (rst)
            fetch_count <= '0;
        else if (ir_valid_q && bus.ir_ready && !redirect_valid)
            fetch_count <= fetch_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus randomized traffic for instr_fetch,
// compared against a transaction-level reference model.
// Build with INSTR_FETCH_COUNT_EN defined to also cover fetch_count.
module tb_instr_fetch;

    localparam int PC_W    = 3;
    localparam int INSTR_W = 16;
    localparam int SETTLE  = 1;
    localparam int DEPTH   = 1 << PC_W;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
`ifdef INSTR_FETCH_COUNT_EN
    logic [15:0]     fetch_count;
`endif

    always #5 clk = ~clk;

    instr_fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    instr_fetch #(
        .PC_W       (PC_W),
        .INSTR_W    (INSTR_W),
        .RESET_PC   (0),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
`ifdef INSTR_FETCH_COUNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    // ROM: mem[i] = A000+i; drives a poison value while disabled.
    assign bus.rom_instr = bus.rom_oeb ? 16'hDEAD : (16'hA000 + 16'(bus.rom_pc));

    int nchk  = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a read in flight with m_left cycles to go, a held word,
    // or neither (idle).
    int          m_pc, m_addr, m_left, m_wpc, m_cnt;
    bit          m_have;
    logic [15:0] m_word;

    task automatic model_edge(input bit i_en, i_rdy, i_rdir, input int i_rpc, input bit i_rst);
        if (i_rst) begin
            m_pc = 0; m_addr = 0; m_left = 0; m_have = 0;
            m_word = 16'h0; m_wpc = 0; m_cnt = 0;
        end else if (i_rdir) begin
            m_pc   = i_rpc;
            m_have = 0;
            m_left = 0;
            if (i_en) begin
                m_left = SETTLE;
                m_addr = i_rpc;
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_have = 1;
                m_word = 16'hA000 + 16'(m_addr);
                m_wpc  = m_pc;
                m_pc   = (m_pc + 1) % DEPTH;
            end
        end else if (m_have) begin
            if (i_rdy) begin
                m_have = 0;
                m_cnt  = (m_cnt + 1) % 65536;
                if (i_en) begin
                    m_left = SETTLE;
                    m_addr = m_pc;
                end
            end
        end else if (i_en) begin
            m_left = SETTLE;
            m_addr = m_pc;
        end
    endtask

    task automatic check_outputs();
        chk("ir_valid", 32'(bus.ir_valid), 32'(m_have));
        chk("rom_oeb",  32'(bus.rom_oeb),  32'(m_left == 0));
        chk("rom_pc",   32'(bus.rom_pc),   32'(m_addr));
        chk("ir_instr", 32'(bus.ir_instr), 32'(m_word));
        chk("ir_pc",    32'(bus.ir_pc),    32'(m_wpc));
`ifdef INSTR_FETCH_COUNT_EN
        chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
`endif
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check at negedge.
    task automatic step(input bit i_en, i_rdy, i_rdir, input int i_rpc, input bit i_rst);
        en             = i_en;
        bus.ir_ready   = i_rdy;
        redirect_valid = i_rdir;
        redirect_pc    = PC_W'(i_rpc);
        rst            = i_rst;
        @(posedge clk);
        model_edge(i_en, i_rdy, i_rdir, i_rpc, i_rst);
        @(negedge clk);
        check_outputs();
    endtask

    // mode 0: run until a read is in flight; mode 1: until a word is held.
    task automatic run_until(input int mode, input bit i_rdy);
        bit hit = 0;
        for (int i = 0; i < 16; i++) begin
            if (mode == 0 ? !bus.rom_oeb : bus.ir_valid) begin
                hit = 1;
                break;
            end
            step(1, i_rdy, 0, 0, 0);
        end
        if (!hit) hit = (mode == 0) ? !bus.rom_oeb : bus.ir_valid;
        chk("wait_timeout", 32'(hit), 32'd1);
    endtask

    initial begin
        int k, last, cyc, hs;
        logic [15:0] w;
        logic [PC_W-1:0] p, a;

        rst = 1; en = 0; bus.ir_ready = 0; redirect_valid = 0; redirect_pc = '0;
        @(negedge clk);

        // Reset state
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("rst_valid", 32'(bus.ir_valid), 32'd0);
        chk("rst_oeb",   32'(bus.rom_oeb),  32'd1);
        chk("rst_rompc", 32'(bus.rom_pc),   32'd0);

        // 1: streaming with wrap, one word every 2 cycles
        k = 0; last = 0; cyc = 0;
        while (k < 9 && cyc < 60) begin
            if (bus.ir_valid) begin
                chk("s1_instr", 32'(bus.ir_instr), 32'hA000 + 32'(k % DEPTH));
                chk("s1_pc",    32'(bus.ir_pc),    32'(k % DEPTH));
                if (k > 0) chk("s1_interval", 32'(cyc - last), 32'(SETTLE + 1));
                last = cyc;
                k++;
            end
            step(1, 1, 0, 0, 0);
            cyc++;
        end
        chk("s1_words", 32'(k), 32'd9);

        // 2: stall with ready low
        run_until(1, 0);
        w = bus.ir_instr; p = bus.ir_pc; a = bus.rom_pc;
        repeat (5) begin
            step(1, 0, 0, 0, 0);
            chk("s2_instr", 32'(bus.ir_instr), 32'(w));
            chk("s2_pc",    32'(bus.ir_pc),    32'(p));
            chk("s2_oeb",   32'(bus.rom_oeb),  32'd1);
            chk("s2_rompc", 32'(bus.rom_pc),   32'(a));
        end
        step(1, 1, 0, 0, 0);

        // 3: redirect during REQ
        run_until(0, 1);
        step(1, 0, 1, 5, 0);
        chk("s3_novalid", 32'(bus.ir_valid), 32'd0);
        run_until(1, 0);
        chk("s3_instr", 32'(bus.ir_instr), 32'hA005);
        chk("s3_pc",    32'(bus.ir_pc),    32'd5);
        step(1, 1, 0, 0, 0);

        // 4: en dropped mid-REQ
        run_until(0, 1);
        step(0, 0, 0, 0, 0);
        chk("s4_delivered", 32'(bus.ir_valid), 32'd1);
        step(0, 1, 0, 0, 0);
        chk("s4_valid", 32'(bus.ir_valid), 32'd0);
        chk("s4_oeb",   32'(bus.rom_oeb),  32'd1);
        step(0, 0, 0, 0, 0);
        chk("s4_idle_oeb", 32'(bus.rom_oeb), 32'd1);

        // 5: reset in REQ and in VALID
        run_until(0, 1);
        step(1, 0, 0, 0, 1);
        chk("s5r_valid", 32'(bus.ir_valid), 32'd0);
        chk("s5r_oeb",   32'(bus.rom_oeb),  32'd1);
        chk("s5r_rompc", 32'(bus.rom_pc),   32'd0);
        run_until(1, 0);
        step(1, 0, 0, 0, 1);
        chk("s5v_valid", 32'(bus.ir_valid), 32'd0);
        chk("s5v_oeb",   32'(bus.rom_oeb),  32'd1);
        chk("s5v_rompc", 32'(bus.rom_pc),   32'd0);

`ifdef INSTR_FETCH_COUNT_EN
        // 6: ten handshakes plus a ready that collides with a redirect
        step(0, 0, 0, 0, 1);
        hs = 0; cyc = 0;
        while (hs < 10 && cyc < 80) begin
            if (bus.ir_valid) hs++;
            step(1, 1, 0, 0, 0);
            cyc++;
        end
        run_until(1, 0);
        step(1, 1, 1, 3, 0);
        chk("s6_count", 32'(fetch_count), 32'd10);
`else
        hs = 0;
`endif

        // Randomized traffic
        repeat (1500) begin
            step(($urandom % 10) < 8, ($urandom % 10) < 7, ($urandom % 10) == 0,
                 int'($urandom % DEPTH), ($urandom % 50) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
